uncache_data_resp: RTL and testbench



---
 rtl/uncache_data_resp_pkg.sv | 28 ++
 rtl/uncache_data_resp.sv | 153 +++++++++++++++
 tb/tb_uncache_data_resp.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uncache_data_resp_pkg.sv
// Shared types for the uncached data responder: FSM states and bus access-size codes.
// Optional feature macro used by the top: UNCACHE_POSTED_STORE_EN.
package uncache_data_resp_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_RD_REQ   = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_DRAIN = 3'd4,
        S_WR_REQ   = 3'd5
    } uc_state_e;

    localparam logic [2:0] BUS_TYPE_BYTE = 3'd0;
    localparam logic [2:0] BUS_TYPE_HALF = 3'd1;
    localparam logic [2:0] BUS_TYPE_WORD = 3'd2;

    function automatic logic [2:0] size_to_type(input logic [1:0] size);
        logic [2:0] t;
        case (size)
            2'd0:    t = BUS_TYPE_BYTE;
            2'd1:    t = BUS_TYPE_HALF;
            default: t = BUS_TYPE_WORD;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/uncache_data_resp.sv
// Single-beat uncached load/store responder beside the dcache; answers only lookups flagged uncached.
// Define UNCACHE_POSTED_STORE_EN to acknowledge stores as soon as they leave LOOKUP.
module uncache_data_resp
    import uncache_data_resp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_vaddr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    input  logic [19:0] data_tag,
    input  logic        data_uncache_en,
    input  logic        tlb_excp_cancel_req,
    input  logic        flush,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,
    output logic        wr_req,
    output logic [2:0]  wr_type,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_wstrb,
    output logic [31:0] wr_data,
    input  logic        wr_rdy,
    output uc_state_e   dbg_state
);

    // Handshakes: a request transfers in a cycle where both data_req and data_addr_ok are high;
    // rd_req/wr_req hold address, type and data stable until rd_rdy/wr_rdy is seen with them.
    uc_state_e   state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] paddr_q, paddr_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        size_d    = size_q;
        wstrb_d   = wstrb_q;
        vaddr_d   = vaddr_q;
        wdata_d   = wdata_q;
        paddr_d   = paddr_q;
        data_ok_d = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (data_req) begin
                    wr_d    = data_wr;
                    size_d  = data_size;
                    wstrb_d = data_wstrb;
                    vaddr_d = data_vaddr;
                    wdata_d = data_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (flush || tlb_excp_cancel_req || !data_uncache_en) begin
                    state_d = S_IDLE;
                end else begin
                    paddr_d = {data_tag, vaddr_q[11:0]};
                    state_d = wr_q ? S_WR_REQ : S_RD_REQ;
`ifdef UNCACHE_POSTED_STORE_EN
                    data_ok_d = wr_q;
`endif
                end
            end
            S_RD_REQ: begin
                if (flush)       state_d = S_IDLE;
                else if (rd_rdy) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (ret_valid && ret_last) begin
                    state_d = S_IDLE;
                    if (!flush) begin
                        rdata_d   = ret_data;
                        data_ok_d = 1'b1;
                    end
                end else if (flush) begin
                    state_d = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: begin
                if (ret_valid && ret_last) state_d = S_IDLE;
            end
            S_WR_REQ: begin
`ifdef UNCACHE_POSTED_STORE_EN
                // Already acknowledged, so the write must reach the bus regardless of flush.
                if (wr_rdy) state_d = S_IDLE;
`else
                if (flush) begin
                    state_d = S_IDLE;
                end else if (wr_rdy) begin
                    state_d   = S_IDLE;
                    data_ok_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            wstrb_q   <= 4'd0;
            vaddr_q   <= 32'd0;
            wdata_q   <= 32'd0;
            paddr_q   <= 32'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            vaddr_q   <= vaddr_d;
            wdata_q   <= wdata_d;
            paddr_q   <= paddr_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign data_addr_ok = (state_q == S_IDLE);
    assign data_data_ok = data_ok_q;
    assign data_rdata   = rdata_q;
    assign rd_req       = (state_q == S_RD_REQ);
    assign rd_type      = size_to_type(size_q);
    assign rd_addr      = paddr_q;
    assign wr_req       = (state_q == S_WR_REQ);
    assign wr_type      = size_to_type(size_q);
    assign wr_addr      = paddr_q;
    assign wr_wstrb     = wstrb_q;
    assign wr_data      = wdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uncache_data_resp.sv
// Directed bench for uncache_data_resp: per-cycle vector table for load paths, hand sequences for stores and reset.
module tb_uncache_data_resp;
    import uncache_data_resp_pkg::*;

`ifdef UNCACHE_POSTED_STORE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_vaddr, data_wdata;
    logic        data_addr_ok;
    logic [19:0] data_tag;
    logic        data_uncache_en, tlb_excp_cancel_req, flush;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy, ret_valid, ret_last;
    logic [31:0] ret_data;
    logic        wr_req;
    logic [2:0]  wr_type;
    logic [31:0] wr_addr;
    logic [3:0]  wr_wstrb;
    logic [31:0] wr_data;
    logic        wr_rdy;
    uc_state_e   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uncache_data_resp dut (
        .clk(clk), .reset(reset),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_vaddr(data_vaddr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_tag(data_tag), .data_uncache_en(data_uncache_en),
        .tlb_excp_cancel_req(tlb_excp_cancel_req), .flush(flush),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        req;
        logic [1:0]  size;
        logic [31:0] vaddr;
        logic [19:0] tag;
        logic        unc;
        logic        cancel;
        logic        fl;
        logic        rrdy;
        logic        rv;
        logic        rl;
        logic [31:0] rd;
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_rdata;
        logic        e_rreq;
        logic [31:0] e_raddr;
        logic [2:0]  e_rtype;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic req, logic [1:0] size, logic [31:0] vaddr, logic unc,
                                logic cancel, logic fl, logic rrdy, logic rv, logic rl,
                                logic [31:0] rd, logic e_aok, logic e_dok, logic [31:0] e_rdata,
                                logic e_rreq, logic [31:0] e_raddr, logic [2:0] e_rtype);
        vec_t v;
        v.req = req; v.size = size; v.vaddr = vaddr; v.tag = 20'h1FE00; v.unc = unc;
        v.cancel = cancel; v.fl = fl; v.rrdy = rrdy; v.rv = rv; v.rl = rl; v.rd = rd;
        v.e_aok = e_aok; v.e_dok = e_dok; v.e_rdata = e_rdata; v.e_rreq = e_rreq;
        v.e_raddr = e_raddr; v.e_rtype = e_rtype;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_vaddr = 0; data_wdata = 0;
        data_tag = 0; data_uncache_en = 0; tlb_excp_cancel_req = 0; flush = 0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0;
    endtask

    task automatic drive_store(input logic [1:0] size, input logic [3:0] wstrb,
                               input logic [31:0] vaddr, input logic [31:0] wdata);
        data_req = 1; data_wr = 1; data_size = size; data_wstrb = wstrb;
        data_vaddr = vaddr; data_wdata = wdata;
    endtask

    task automatic drive_lookup();
        data_tag = 20'h1FE00; data_uncache_en = 1;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        check("reset addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("reset data_ok", {31'd0, data_data_ok}, 32'd0);
        check("reset rdata", data_rdata, 32'd0);
        check("reset rd_req", {31'd0, rd_req}, 32'd0);
        check("reset wr_req", {31'd0, wr_req}, 32'd0);
        check("reset rd_addr", rd_addr, 32'd0);
        check("reset wr_data", wr_data, 32'd0);
        check("reset wr_wstrb", {28'd0, wr_wstrb}, 32'd0);
        check("reset types", {26'd0, rd_type, wr_type}, 32'd0);

        // Columns: req size vaddr unc cancel flush rd_rdy ret_v ret_l ret_d | aok dok rdata rd_req rd_addr rd_type
        // Word load, zero wait states
        vecs.push_back(mk(1, 2, 32'h1FE0_01E4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1FE0_01E4, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // TLB cancel in lookup, then non-uncached lookup
        vecs.push_back(mk(1, 2, 32'h0000_0010, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Half load flushed in RD_WAIT, last beat two cycles later
        vecs.push_back(mk(1, 1, 32'h1FE0_0102, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1FE0_0102, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Flush together with rd_rdy in RD_REQ; a stray beat afterwards is ignored
        vecs.push_back(mk(1, 2, 32'h1FE0_0200, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1FE0_0200, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_F00D, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Flush in the same cycle as the last beat
        vecs.push_back(mk(1, 0, 32'h1FE0_0301, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1FE0_0301, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h0BAD_BEEF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clear_inputs();
            data_req = vecs[i].req; data_size = vecs[i].size; data_vaddr = vecs[i].vaddr;
            data_tag = vecs[i].tag; data_uncache_en = vecs[i].unc;
            tlb_excp_cancel_req = vecs[i].cancel; flush = vecs[i].fl; rd_rdy = vecs[i].rrdy;
            ret_valid = vecs[i].rv; ret_last = vecs[i].rl; ret_data = vecs[i].rd;
            #1;
            check($sformatf("vec%0d addr_ok", i), {31'd0, data_addr_ok}, {31'd0, vecs[i].e_aok});
            check($sformatf("vec%0d data_ok", i), {31'd0, data_data_ok}, {31'd0, vecs[i].e_dok});
            check($sformatf("vec%0d rd_req", i), {31'd0, rd_req}, {31'd0, vecs[i].e_rreq});
            check($sformatf("vec%0d wr_req", i), {31'd0, wr_req}, 32'd0);
            if (vecs[i].e_dok)
                check($sformatf("vec%0d rdata", i), data_rdata, vecs[i].e_rdata);
            if (vecs[i].e_rreq) begin
                check($sformatf("vec%0d rd_addr", i), rd_addr, vecs[i].e_raddr);
                check($sformatf("vec%0d rd_type", i), {29'd0, rd_type}, {29'd0, vecs[i].e_rtype});
            end
        end

        // Byte store, wr_rdy arrives on the fourth WR_REQ cycle
        @(negedge clk); clear_inputs();
        drive_store(2'd0, 4'b0100, 32'h1FE0_0003, 32'h00AB_0000);
        #1 check("st accept addr_ok", {31'd0, data_addr_ok}, 32'd1);
        @(negedge clk); clear_inputs(); drive_lookup();
        #1 check("st lookup wr_req", {31'd0, wr_req}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); clear_inputs(); wr_rdy = (k == 3);
            #1;
            check($sformatf("st hold%0d wr_req", k), {31'd0, wr_req}, 32'd1);
            check($sformatf("st hold%0d wr_addr", k), wr_addr, 32'h1FE0_0003);
            check($sformatf("st hold%0d wr_wstrb", k), {28'd0, wr_wstrb}, 32'h4);
            check($sformatf("st hold%0d wr_data", k), wr_data, 32'h00AB_0000);
            check($sformatf("st hold%0d wr_type", k), {29'd0, wr_type}, 32'd0);
            check($sformatf("st hold%0d addr_ok", k), {31'd0, data_addr_ok}, 32'd0);
            check($sformatf("st hold%0d data_ok", k), {31'd0, data_data_ok}, {31'd0, POSTED && (k == 0)});
        end
        @(negedge clk); clear_inputs();
        #1;
        check("st done wr_req", {31'd0, wr_req}, 32'd0);
        check("st done addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("st done data_ok", {31'd0, data_data_ok}, {31'd0, !POSTED});
        @(negedge clk); #1 check("st after data_ok", {31'd0, data_data_ok}, 32'd0);

        // Flush in WR_REQ together with wr_rdy
        @(negedge clk); clear_inputs();
        drive_store(2'd2, 4'b1111, 32'h1FE0_0010, 32'h1122_3344);
        @(negedge clk); clear_inputs(); drive_lookup();
        @(negedge clk); clear_inputs(); flush = 1; wr_rdy = 1;
        #1;
        check("stfl wr_req", {31'd0, wr_req}, 32'd1);
        check("stfl data_ok", {31'd0, data_data_ok}, {31'd0, POSTED});
        @(negedge clk); clear_inputs();
        #1;
        check("stfl idle addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("stfl no data_ok", {31'd0, data_data_ok}, 32'd0);
        @(negedge clk); #1 check("stfl still no data_ok", {31'd0, data_data_ok}, 32'd0);

        // Back-to-back load then store, data_req held high throughout
        @(negedge clk); clear_inputs();
        data_req = 1; data_size = 2; data_vaddr = 32'h1FE0_0400;
        #1 check("b2b load accept", {31'd0, data_addr_ok}, 32'd1);
        @(negedge clk); clear_inputs(); drive_store(2'd1, 4'b0011, 32'h1FE0_0402, 32'h0000_BEEF); drive_lookup();
        #1 check("b2b lookup addr_ok", {31'd0, data_addr_ok}, 32'd0);
        @(negedge clk); rd_rdy = 1; data_uncache_en = 0;
        #1 check("b2b rd_req addr_ok", {31'd0, data_addr_ok}, 32'd0);
        @(negedge clk); rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'h55AA_55AA;
        #1 check("b2b wait addr_ok", {31'd0, data_addr_ok}, 32'd0);
        @(negedge clk); ret_valid = 0; ret_last = 0; ret_data = 0;
        #1;
        check("b2b load data_ok", {31'd0, data_data_ok}, 32'd1);
        check("b2b load rdata", data_rdata, 32'h55AA_55AA);
        check("b2b store accept", {31'd0, data_addr_ok}, 32'd1);
        @(negedge clk); clear_inputs(); drive_lookup();
        #1 check("b2b st lookup addr_ok", {31'd0, data_addr_ok}, 32'd0);
        @(negedge clk); clear_inputs(); wr_rdy = 1;
        #1;
        check("b2b st wr_req", {31'd0, wr_req}, 32'd1);
        check("b2b st wr_addr", wr_addr, 32'h1FE0_0402);
        check("b2b st wr_wstrb", {28'd0, wr_wstrb}, 32'h3);
        check("b2b st wr_type", {29'd0, wr_type}, 32'd1);
        check("b2b st posted ok", {31'd0, data_data_ok}, {31'd0, POSTED});
        @(negedge clk); clear_inputs();
        #1;
        check("b2b st done addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("b2b st done data_ok", {31'd0, data_data_ok}, {31'd0, !POSTED});

        // Reset while in RD_WAIT
        @(negedge clk); clear_inputs(); data_req = 1; data_size = 2; data_vaddr = 32'h1FE0_0500;
        @(negedge clk); clear_inputs(); drive_lookup();
        @(negedge clk); clear_inputs(); rd_rdy = 1;
        #1 check("rst pre rd_req", {31'd0, rd_req}, 32'd1);
        @(negedge clk); clear_inputs(); reset = 1;
        #1 check("rst in rd_wait addr_ok", {31'd0, data_addr_ok}, 32'd0);
        @(negedge clk); reset = 0;
        #1;
        check("rst after addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("rst after rd_req", {31'd0, rd_req}, 32'd0);
        check("rst after rd_addr", rd_addr, 32'd0);
        check("rst after rdata", data_rdata, 32'd0);
        check("rst after data_ok", {31'd0, data_data_ok}, 32'd0);
        check("rst after wr bus", {wr_data[31:4], wr_wstrb | wr_data[3:0]}, 32'd0);
        check("rst after types", {26'd0, rd_type, wr_type}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
